mult_seq_n: RTL and testbench
=============================

# mult_seq_n

Parametrised sequential shift-add multiplier for the lab datapath. It multiplies a WIDTH-bit multiplier held in register B by a WIDTH-bit multiplicand captured from the switch bus, producing a 2·WIDTH-bit product in {A,B}. Each operation can be run in signed (two's complement) or unsigned mode, and each multiplier bit takes one clock. The block feeds the hex-display driver and the board LEDs, and is the parametrised successor to the fixed 8-bit Clr_Ld/Add/Sub/Shift multiplier.

## Interface
- WIDTH, 8, operand width in bits; must be at least 2.
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Din  in  WIDTH  operand bus (switches): the value loaded into B on Load, and the multiplicand M captured on start.
- Load  in  1  synchronous, level-sensitive, active-high: load B and clear X:A.
- Run  in  1  synchronous, active-high; the rising edge starts an operation.
- Signed_Mode  in  1  1 = two's complement, 0 = unsigned; sampled at start.
- Busy  out  1  high while computing.
- Done  out  1  one-cycle pulse when the product is valid.
- Product  out  2·WIDTH  {A,B} latched at completion; held until the next completion.
- Aval  out  WIDTH  live A register.
- Bval  out  WIDTH  live B register.
- Xval  out  1  live extension bit X.

## Operation
- States: IDLE, CALC, DONE.
- Reset values: state IDLE; X, A, B, M, count, Product all 0; Run_q 0; Busy 0; Done 0; mode register 0.
- Start detection: start = Run & ~Run_q. Run_q updates every cycle in every state.
- Load in IDLE or DONE:
  - B ← Din, A ← 0, X ← 0.
  - State becomes IDLE.
- Start in IDLE or DONE:
  - M ← Din, A ← 0, X ← 0, count ← 0.
  - Mode register ← Signed_Mode.
  - State becomes CALC.
  - B is kept, so a second Run without Load multiplies the previous low half by the new M (chained multiply).
- Simultaneous Load and start: Load wins. The start is discarded, and Run must fall and rise again.
- In CALC, Load and start are ignored. Run held high through completion never restarts the block.
- CALC step, one per cycle:
  - Addend: if B[0] = 0, add 0. If B[0] = 1, add M, except in signed mode on the last step (count = WIDTH−1), where M is subtracted.
  - Signed mode: S = {X,A} + sign-extended M (or minus it), computed in WIDTH+1 bits.
  - Unsigned mode: S = {X,A} + {0,M}, with X holding the carry.
  - Shift: {X,A,B} ← {fill, S, B} >> 1 over 2·WIDTH+1 bits. Fill is S[WIDTH] in signed mode and 0 in unsigned mode.
  - count increments.
- Leaving CALC: after the step with count = WIDTH−1:
  - Product ← final {A,B}.
  - Done pulses.
  - State becomes DONE.
- DONE: Busy 0; A, B and Product hold until the next Load or start.
- All arithmetic wraps modulo 2^(WIDTH+1). Overflow is impossible for the full product, including signed −2^(W−1) × −2^(W−1).

## Timing
- Start sampled at edge k. Steps occur at edges k+1 … k+WIDTH. Product is valid and Done is high for the cycle following edge k+WIDTH.
- Latency from the start edge is WIDTH+1 cycles.
- Busy is high from edge k until edge k+WIDTH.
- Back-to-back operation: a new Run rising edge is accepted in the first DONE cycle.
- Reset_n low mid-operation clears everything immediately, without waiting for a clock. No Done pulse is issued.
- Aval, Bval and Xval change every CALC cycle; they are debug observation only.

## Structure
- Package mult_seq_pkg holds:
  - the state enum typedef (IDLE, CALC, DONE);
  - the localparam for counter width, $clog2(WIDTH+1).
- Sub-module addsub_n (parameter WIDTH): WIDTH+1-bit combinational add/subtract with a Sub control and a sign-extend-versus-zero-extend control.
- The FSM, counter, X/A/B/M registers and edge detector live in mult_seq_n.

## Test plan
Scenarios 1–5 use WIDTH = 8; scenario 6 uses WIDTH = 16.
1. Signed 7 × 59: Load B = 0x07, Run with Din = 0x3B, Signed_Mode = 1 → Done at cycle 9 after the start edge; Product = 0x019D.
2. Signed and unsigned extremes:
   - Signed 0xFF × 0xFF → 0x0001.
   - Signed 0x80 × 0x80 → 0x4000.
   - Signed 0x80 × 0x7F → 0xC080.
   - Unsigned 0xFF × 0xFF → 0xFE01.
3. Chained multiply: after scenario 1, Run with Din = 0x02 and no Load → signed Product = 0xFF3A; in unsigned mode Product = 0x013A.
4. Run handling:
   - Run held high for 30 cycles → exactly one Done pulse.
   - A Run re-pulse or a Load during CALC → ignored; Product unchanged.
   - Load and Run rising in the same cycle → B loaded, no start.
5. Reset_n low at step 4 of a run → all outputs 0 with no clock edge needed. After release, Load 0x03 then Run 0x05 → Product = 0x000F.
6. WIDTH = 16 signed: 0x8000 × 0xFFFF → 0x00008000, with Done 17 cycles after the start edge.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
//   state_e          : controller states (idle / calculating / done)
//   cnt_width()      : step-counter width for a given operand width, $clog2(WIDTH+1)
//   DefaultCntWidth  : counter width for the default 8-bit build
package mult_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefaultWidth    = 8;
    localparam int unsigned DefaultCntWidth = $clog2(DefaultWidth + 1);

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/addsub_n.sv
// WIDTH+1-bit combinational adder/subtractor for one multiply step.
//   a_i    : WIDTH+1-bit accumulator {X,A}
//   b_i    : WIDTH-bit addend (already zero when the multiplier bit is 0)
//   sub_i  : 1 = a_i - b_i, 0 = a_i + b_i
//   sext_i : 1 = sign-extend b_i, 0 = zero-extend b_i
//   sum_o  : WIDTH+1-bit result, wraps modulo 2^(WIDTH+1)
module addsub_n #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             sext_i,
    output logic [WIDTH:0]   sum_o
);

    logic [WIDTH:0] b_ext;

    always_comb begin
        b_ext = {sext_i & b_i[WIDTH-1], b_i};
        sum_o = sub_i ? (a_i - b_ext) : (a_i + b_ext);
    end

endmodule

// File: rtl/mult_seq_n.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   Din          : operand bus; B on Load, multiplicand M on start
//   Load         : load B and clear X:A (idle/done only)
//   Run          : rising edge starts an operation (idle/done only)
//   Signed_Mode  : 1 = two's complement, sampled at start
//   Busy, Done   : computing flag, one-cycle completion pulse
//   Product      : {A,B} latched at completion
//   Aval/Bval/Xval : live A, B, X registers (debug)
module mult_seq_n
    import mult_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [WIDTH-1:0]   Din,
    input  logic               Load,
    input  logic               Run,
    input  logic               Signed_Mode,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product,
    output logic [WIDTH-1:0]   Aval,
    output logic [WIDTH-1:0]   Bval,
    output logic               Xval
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e               state_q, state_d;
    logic                 x_q, x_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 sgn_q, sgn_d;
    logic                 done_q, done_d;
    logic                 run_q;

    logic                 start;
    logic                 last;
    logic                 fill;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;

    assign start  = Run & ~run_q;
    assign last   = (cnt_q == CntW'(WIDTH - 1));
    assign addend = b_q[0] ? m_q : '0;
    // Unsigned mode keeps the carry in X, so the shift brings in a zero.
    assign fill   = sgn_q ? sum[WIDTH] : 1'b0;

    // Sign bit of the multiplier carries negative weight: subtract on the last step.
    addsub_n #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a_i    ({x_q, a_q}),
        .b_i    (addend),
        .sub_i  (sgn_q & last),
        .sext_i (sgn_q),
        .sum_o  (sum)
    );

    // State register and datapath flops.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            sgn_q   <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            sgn_q   <= sgn_d;
            done_q  <= done_d;
            run_q   <= Run;
        end
    end

    // Next-state logic; Load takes priority over a start in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (Load) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (last) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values.
    always_comb begin
        x_d    = x_q;
        a_d    = a_q;
        b_d    = b_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        prod_d = prod_q;
        sgn_d  = sgn_q;
        done_d = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (Load) begin
                    b_d = Din;
                    a_d = '0;
                    x_d = 1'b0;
                end else if (start) begin
                    // B is kept so a Run without Load chains on the previous low half.
                    m_d   = Din;
                    a_d   = '0;
                    x_d   = 1'b0;
                    cnt_d = '0;
                    sgn_d = Signed_Mode;
                end
            end
            StCalc: begin
                x_d   = fill;
                a_d   = sum[WIDTH:1];
                b_d   = {sum[0], b_q[WIDTH-1:1]};
                cnt_d = cnt_q + CntW'(1);
                if (last) begin
                    prod_d = {sum[WIDTH:1], sum[0], b_q[WIDTH-1:1]};
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        Busy    = (state_q == StCalc);
        Done    = done_q;
        Product = prod_q;
        Aval    = a_q;
        Bval    = b_q;
        Xval    = x_q;
    end

endmodule

// File: tb/tb_mult_seq_n.sv
module tb_mult_seq_n;

    logic        clk;
    logic        rst_n;

    logic [7:0]  din8;
    logic        load8, run8, sm8;
    logic        busy8, done8, xval8;
    logic [15:0] prod8;
    logic [7:0]  aval8, bval8;

    logic [15:0] din16;
    logic        load16, run16, sm16;
    logic        busy16, done16, xval16;
    logic [31:0] prod16;
    logic [15:0] aval16, bval16;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    mult_seq_n #(.WIDTH(8)) dut8 (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .Din         (din8),
        .Load        (load8),
        .Run         (run8),
        .Signed_Mode (sm8),
        .Busy        (busy8),
        .Done        (done8),
        .Product     (prod8),
        .Aval        (aval8),
        .Bval        (bval8),
        .Xval        (xval8)
    );

    mult_seq_n #(.WIDTH(16)) dut16 (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .Din         (din16),
        .Load        (load16),
        .Run         (run16),
        .Signed_Mode (sm16),
        .Busy        (busy16),
        .Done        (done16),
        .Product     (prod16),
        .Aval        (aval16),
        .Bval        (bval16),
        .Xval        (xval16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endfunction

    // Full-width product of two 8-bit operands, computed by plain arithmetic.
    function automatic logic [15:0] mul8(input logic [7:0] b, input logic [7:0] m,
                                         input logic sg);
        logic [15:0] be, me;
        be = sg ? {{8{b[7]}}, b} : {8'h00, b};
        me = sg ? {{8{m[7]}}, m} : {8'h00, m};
        return be * me;
    endfunction

    // Transaction-level model of the 8-bit instance: an operation occupies
    // WIDTH cycles after the start edge, then the product appears.
    logic        m_busy, m_done, m_sg, m_run_q;
    logic [15:0] m_prod;
    logic [7:0]  m_a, m_b, m_m;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_done <= 0; m_sg <= 0; m_run_q <= 0;
            m_prod <= 0; m_a <= 0; m_b <= 0; m_m <= 0; m_left <= 0;
        end else begin
            m_done <= 0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 0;
                    m_done <= 1;
                    m_prod <= mul8(m_b, m_m, m_sg);
                    {m_a, m_b} <= mul8(m_b, m_m, m_sg);
                end
                m_left <= m_left - 1;
            end else if (load8) begin
                m_b <= din8;
                m_a <= 0;
            end else if (run8 && !m_run_q) begin
                m_busy <= 1;
                m_left <= 8;
                m_m    <= din8;
                m_sg   <= sm8;
                m_a    <= 0;
            end
            m_run_q <= run8;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", 32'(busy8), 32'(m_busy));
            check("done", 32'(done8), 32'(m_done));
            check("product", 32'(prod8), 32'(m_prod));
            if (!m_busy) begin
                check("aval", 32'(aval8), 32'(m_a));
                check("bval", 32'(bval8), 32'(m_b));
            end
        end
    end

    task automatic load_b(input logic [7:0] v);
        @(negedge clk);
        din8  = v;
        load8 = 1;
        @(negedge clk);
        load8 = 0;
    endtask

    // Start an operation and wait (bounded) for Done; latency counts the
    // start edge as cycle 1.
    task automatic run_op(input logic [7:0] d, input logic s, input logic [15:0] lit,
                          input bit no_wait);
        int lat;
        bit got;
        if (!no_wait) @(negedge clk);
        din8 = d;
        sm8  = s;
        run8 = 1;
        lat  = 0;
        got  = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (i == 1) run8 = 0;
            if (done8) begin
                got = 1;
                lat = i;
            end
        end
        check("latency8", 32'(lat), 32'd9);
        check("product_literal", 32'(prod8), 32'(lit));
        check("model_literal", 32'(m_prod), 32'(lit));
    endtask

    initial begin
        int pulses;
        int lat;
        bit got;
        rst_n = 0;
        din8 = 0; load8 = 0; run8 = 0; sm8 = 0;
        din16 = 0; load16 = 0; run16 = 0; sm16 = 0;
        #3;
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_prod8", 32'(prod8), 32'd0);
        check("rst_busy16", 32'(busy16), 32'd0);
        check("rst_prod16", prod16, 32'd0);
        @(negedge clk);
        rst_n  = 1;
        cmp_en = 1;

        // Basic signed, then chained multiplies.
        load_b(8'h07);
        run_op(8'h3B, 1'b1, 16'h019D, 0);
        run_op(8'h02, 1'b1, 16'hFF3A, 0);
        load_b(8'h07);
        run_op(8'h3B, 1'b1, 16'h019D, 0);
        run_op(8'h02, 1'b0, 16'h013A, 0);

        // Extremes.
        load_b(8'hFF); run_op(8'hFF, 1'b1, 16'h0001, 0);
        load_b(8'h80); run_op(8'h80, 1'b1, 16'h4000, 0);
        load_b(8'h80); run_op(8'h7F, 1'b1, 16'hC080, 0);
        load_b(8'hFF); run_op(8'hFF, 1'b0, 16'hFE01, 0);

        // Back-to-back: new Run rises in the first Done cycle (B = 0x0F then).
        load_b(8'h03);
        run_op(8'h05, 1'b0, 16'h000F, 0);
        run_op(8'h02, 1'b0, 16'h001E, 1);

        // Run held high: one Done pulse only.
        load_b(8'h06);
        @(negedge clk);
        din8 = 8'h05; sm8 = 0; run8 = 1;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        run8 = 0;
        check("held_pulses", 32'(pulses), 32'd1);
        check("held_product", 32'(prod8), 32'h001E);

        // Run re-pulse and Load during CALC are ignored.
        load_b(8'h03);
        @(negedge clk);
        din8 = 8'h05; sm8 = 0; run8 = 1;
        @(negedge clk); run8 = 0;
        @(negedge clk); run8 = 1; load8 = 1; din8 = 8'hAA;
        @(negedge clk); run8 = 0; load8 = 0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        check("calc_ignore_pulses", 32'(pulses), 32'd1);
        check("calc_ignore_product", 32'(prod8), 32'h000F);

        // Load and Run rising together: load wins, no start.
        @(negedge clk);
        din8 = 8'h11; load8 = 1; run8 = 1;
        @(negedge clk);
        load8 = 0;
        check("load_run_busy", 32'(busy8), 32'd0);
        check("load_run_bval", 32'(bval8), 32'h11);
        repeat (3) @(negedge clk);
        check("load_run_nostart", 32'(busy8), 32'd0);
        run8 = 0;

        // Asynchronous reset mid-operation.
        load_b(8'h07);
        @(negedge clk);
        din8 = 8'h3B; sm8 = 1; run8 = 1;
        @(negedge clk); run8 = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("arst_busy", 32'(busy8), 32'd0);
        check("arst_done", 32'(done8), 32'd0);
        check("arst_prod", 32'(prod8), 32'd0);
        check("arst_aval", 32'(aval8), 32'd0);
        check("arst_bval", 32'(bval8), 32'd0);
        check("arst_xval", 32'(xval8), 32'd0);
        @(negedge clk);
        rst_n = 1;
        load_b(8'h03);
        run_op(8'h05, 1'b0, 16'h000F, 0);

        // 16-bit instance: 0x8000 x 0xFFFF signed.
        @(negedge clk);
        din16 = 16'h8000; load16 = 1;
        @(negedge clk);
        load16 = 0;
        din16 = 16'hFFFF; sm16 = 1; run16 = 1;
        lat = 0; got = 0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk);
            if (i == 1) begin
                run16 = 0;
                check("busy16", 32'(busy16), 32'd1);
            end
            if (done16) begin
                got = 1;
                lat = i;
            end
        end
        check("latency16", 32'(lat), 32'd17);
        check("product16", prod16, 32'h00008000);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
